// File: rtl/output_interface_pkg.sv
// Shared definitions for the AES wrapper byte-serial ports (input loader and
// output streamer): FSM state encodings and default geometry.
package aes_if_pkg;

  localparam int NBYTES_DEF = 16;
  localparam int DW_DEF     = 8;

  // Input-side loader states
  localparam logic [1:0] C_ID = 2'b00;
  localparam logic [1:0] C_SP = 2'b01;
  localparam logic [1:0] C_SK = 2'b10;
  localparam logic [1:0] C_ST = 2'b11;

  // Output-side streamer states
  localparam logic [1:0] O_ID = 2'b00;
  localparam logic [1:0] O_TX = 2'b01;

endpackage

// File: rtl/output_interface_if.sv
// Host byte port of the AES output streamer: dout/dout_valid/dout_ready.
// Optional even-parity sideband dout_par when OUTPUT_INTERFACE_PARITY_EN is defined.
interface output_interface_if
  import aes_if_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
`ifdef OUTPUT_INTERFACE_PARITY_EN
  logic          dout_par;

  modport master (output dout, output dout_valid, output dout_par, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_par, output dout_ready);
`else
  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
`endif

endinterface

// File: rtl/output_interface_edge_rise_det.sv
// Level sampler with rising-edge pulse. The sample register resets to 1 so a
// signal that is already high at reset release does not look like an edge.
module edge_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sample_q;
  logic sample_d;

  // Next sample is simply the current level.
  always_comb begin
    sample_d = din;
  end

  // Registered copy of din, async active-high reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= 1'b1;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign rise = ~sample_q & din;

endmodule

// File: rtl/output_interface.sv
// AES return path: captures the 128-bit ciphertext on the engine's busy->done
// edge and streams it MSB byte first over a valid/ready host port.
// Optional OUTPUT_INTERFACE_PARITY_EN adds a registered even-parity bit.
module output_interface
  import aes_if_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 engine_done,
  input  logic [NBYTES*DW-1:0] cipher_in,
  output_interface_if.master   host,
  output logic                 ct_busy,
  output logic                 block_done,
  output logic                 overrun
);

  localparam int              IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  logic [1:0]           state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [NBYTES*DW-1:0] cap_q, cap_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 completion;
  logic [IDXW-1:0]      idx_inc;
  logic [DW-1:0]        next_byte;

  edge_rise_det u_eng_edge (
    .clk  (clk),
    .rst  (rst_),
    .din  (engine_done),
    .rise (completion)
  );

  // Byte following the one currently presented (MSB-first order).
  always_comb begin
    idx_inc   = idx_q + IDXW'(1);
    next_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_inc == IDXW'(i)) begin
        next_byte = cap_q[(NBYTES-1-i)*DW +: DW];
      end
    end
  end

  // Streaming FSM: capture on completion edge, advance on each accepted byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      O_ID: begin
        if (completion) begin
          cap_d   = cipher_in;
          idx_d   = '0;
          dout_d  = cipher_in[NBYTES*DW-1 -: DW];
          state_d = O_TX;
        end
      end
      O_TX: begin
        // A completion while streaming is dropped and flagged.
        if (completion) begin
          ovr_d = 1'b1;
        end
        if (host.dout_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            dout_d  = '0;
            done_d  = 1'b1;
            state_d = O_ID;
          end else begin
            idx_d  = idx_inc;
            dout_d = next_byte;
          end
        end
      end
      default: begin
        state_d = O_ID;
        idx_d   = '0;
        dout_d  = '0;
      end
    endcase
  end

  // State, capture and output registers with async active-high reset.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= O_ID;
      idx_q   <= '0;
      cap_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef OUTPUT_INTERFACE_PARITY_EN
  logic par_q;

  // Even parity tracks dout, so it is held whenever dout is held.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^dout_d;
    end
  end

  assign host.dout_par = par_q;
`endif

  assign host.dout       = dout_q;
  assign host.dout_valid = (state_q == O_TX);
  assign ct_busy         = (state_q == O_TX);
  assign block_done      = done_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_output_interface.sv
// Testbench for output_interface: directed scenarios plus randomized traffic
// against a queue-based reference model of the byte stream.
module tb_output_interface;

  localparam int NB = 16;
  localparam int W  = 8;
  localparam logic [127:0] CT = 128'h3925841D02DC09FBDC118597196A0B32;

  logic         clk = 1'b0;
  logic         rst_ = 1'b1;
  logic         engine_done = 1'b1;
  logic [127:0] cipher_in = '0;
  logic         ct_busy, block_done, overrun;

  output_interface_if #(.DW(W)) host ();

  output_interface #(.NBYTES(NB), .DW(W)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .engine_done (engine_done),
    .cipher_in   (cipher_in),
    .host        (host),
    .ct_busy     (ct_busy),
    .block_done  (block_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_bytes [16] = '{8'h39, 8'h25, 8'h84, 8'h1D, 8'h02, 8'hDC, 8'h09, 8'hFB,
                                 8'hDC, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6A, 8'h0B, 8'h32};

  // Reference model: pending byte queue plus a few flags
  bit         m_busy, m_done, m_ovr, m_eng_prev;
  logic [7:0] m_q[$];
  logic [7:0] got[$];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] c, input int i);
    return c[127-8*i -: 8];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ovr = 0; m_eng_prev = 1;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit rise;
    rise   = !m_eng_prev && engine_done;
    m_done = 0;
    if (rst_) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (rise) m_ovr = 1;
        if (host.dout_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (rise) begin
        for (int i = 0; i < NB; i++) m_q.push_back(byte_of(cipher_in, i));
        m_busy = 1;
      end
      m_eng_prev = engine_done;
    end
  endtask

  task automatic check_outputs();
    check("dout_valid", host.dout_valid, m_busy);
    check("ct_busy", ct_busy, m_busy);
    check("block_done", block_done, m_done);
    check("overrun", overrun, m_ovr);
    if (m_busy) begin
      check("dout", host.dout, m_q[0]);
`ifdef OUTPUT_INTERFACE_PARITY_EN
      check("dout_par", host.dout_par, ^m_q[0]);
`endif
    end
  endtask

  task automatic step();
    logic       acc;
    logic [7:0] b;
    acc = host.dout_valid && host.dout_ready;
    b   = host.dout;
    model_edge();
    @(posedge clk);
    #1;
    if (acc && !rst_) got.push_back(b);
    check_outputs();
  endtask

  task automatic fire(input logic [127:0] c, input int nbusy);
    engine_done = 0;
    repeat (nbusy) step();
    engine_done = 1;
    cipher_in   = c;
    step();
  endtask

  task automatic compare_ct(input string tag);
    check({tag, "_count"}, got.size(), 16);
    for (int i = 0; i < 16; i++) check({tag, "_byte"}, got[i], exp_bytes[i]);
  endtask

  initial begin
    int         cyc, stall, phase;
    logic [127:0] c2;
    host.dout_ready = 0;
    model_reset();

    // Reset held for two clocks
    repeat (2) step();
    check("rst_dout", host.dout, 0);
    rst_ = 0;
    repeat (3) step();

    // Basic block, ready held high
    got.delete();
    host.dout_ready = 1;
    fire(CT, 8);
    check("basic_valid_rise", host.dout_valid, 1);
    cyc = 0;
    while (ct_busy && cyc < 40) begin step(); cyc++; end
    check("basic_cycles", cyc, 16);
    check("basic_done_pulse", block_done, 1);
    compare_ct("basic");
    step();

    // Backpressure on byte 4
    got.delete();
    fire(CT, 4);
    cyc = 0; stall = 0;
    while (ct_busy && cyc < 60) begin
      if (got.size() == 4 && stall < 3 && host.dout_valid) begin
        host.dout_ready = 0;
        stall++;
        check("bp_hold", host.dout, 8'h02);
      end else begin
        host.dout_ready = 1;
      end
      step();
      cyc++;
    end
    check("bp_cycles", cyc, 19);
    compare_ct("bp");
    step();

    // Completion during streaming is dropped and flagged
    got.delete();
    host.dout_ready = 1;
    fire(CT, 2);
    cyc = 0; phase = 0;
    while (ct_busy && cyc < 40) begin
      if (got.size() == 6 && phase == 0) begin
        engine_done = 0; phase = 1;
      end else if (phase == 1) begin
        engine_done = 1; cipher_in = '1; phase = 2;
      end
      step();
      cyc++;
    end
    check("ovr_cycles", cyc, 16);
    compare_ct("ovr");
    repeat (3) step();
    check("ovr_sticky", overrun, 1);
    check("ovr_no_new_block", host.dout_valid, 0);

    // Reset in the middle of a block
    got.delete();
    fire(CT, 2);
    cyc = 0;
    while (got.size() < 5 && cyc < 30) begin step(); cyc++; end
    #2 rst_ = 1;
    #1;
    check("midrst_valid", host.dout_valid, 0);
    check("midrst_busy", ct_busy, 0);
    check("midrst_ovr", overrun, 0);
    model_reset();
    repeat (2) step();
    rst_ = 0;
    repeat (4) step();
    c2 = {$urandom, $urandom, $urandom, $urandom};
    got.delete();
    fire(c2, 3);
    cyc = 0;
    while (ct_busy && cyc < 40) begin step(); cyc++; end
    check("post_rst_count", got.size(), 16);
    check("post_rst_first", got[0], byte_of(c2, 0));
    check("post_rst_last", got[15], byte_of(c2, 15));

    // Randomized traffic
    for (int k = 0; k < 1200; k++) begin
      if (engine_done ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 5) == 0))
        engine_done = ~engine_done;
      cipher_in       = {$urandom, $urandom, $urandom, $urandom};
      host.dout_ready = ($urandom_range(0, 3) != 0);
      if (k == 600) rst_ = 1;
      if (k == 602) rst_ = 0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
